io_timer_responder: RTL and testbench
=====================================

Name: io_timer_responder

Overview:
- Memory-mapped IO responder for the two-channel timer/counter peripheral at IO offsets 0x020–0x027. It sits behind the IO decode (upper address bits all ones).
- It answers the CPU's IORead/IOWrite strobes with halfword register reads and writes.
- Each channel down-counts either clock cycles (timer mode) or external pulse edges (counter mode), latches a done status and raises an interrupt request.

Parameters:
- CNT_W, 16, width of count/initial registers (CNT_W <= 16; read data zero-extended to 16 bits)
- BASE_ADDR, 10'h020, low 10 bits of the channel-0 mode register address

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- ior  input  1  IO read strobe (IORead), one cycle per access
- iow  input  1  IO write strobe (IOWrite), one cycle per access
- addr  input  10  low address bits (ALU result [9:0])
- wdata  input  16  write data (store data [15:0])
- rdata  output  16  read data, combinational from addr while ior=1, else 0
- pulse0  input  1  external count input, channel 0 (asynchronous)
- pulse1  input  1  external count input, channel 1 (asynchronous)
- timer_irq  output  1  OR of (done & irq enable) over both channels, registered

Behaviour:
- Register map, offsets from BASE_ADDR:
  - +0: write MODE0; read STATUS0
  - +2: write MODE1; read STATUS1
  - +4: write INIT0; read CNT0
  - +6: write INIT1; read CNT1
  - Any other addr: rdata=0, writes ignored. addr[0]=1 never selects a register.
- MODE bits:
  - [0] src: 0 = timer (tick every clock), 1 = counter (tick on synchronized rising edge of pulseN)
  - [1] repeat
  - [2] irq enable
  - Other bits ignored.
- STATUS bits:
  - [15] running
  - [1] done (counter mode)
  - [0] done (timer mode)
  - Other bits read 0.
- Reset (async, reset_n=0): MODE=0, INIT=0, CNT=0, running=0, done bits=0, sync/edge flops=0, timer_irq=0. rdata follows the combinational rule.
- INIT write:
  - INIT<=wdata, CNT<=wdata, done cleared, running<=(wdata!=0).
  - Writing while running reloads immediately; no tick is applied that cycle.
- MODE write: MODE updated, done bits cleared; CNT and running unchanged.
- Tick while running and CNT>1: CNT<=CNT-1.
- Tick while running and CNT==1:
  - done bit for current src <= 1.
  - If repeat: CNT<=INIT and running stays 1.
  - Else: CNT<=0 and running<=0.
- Period: INIT=N in timer mode gives done set at the edge N cycles after the write edge.
- No ticks while running=0; CNT never wraps below 0.
- STATUS read (ior=1 at that address):
  - rdata shows the pre-edge value.
  - done bits are cleared at that edge, unless a new done is set on the same edge; set wins.
- Counter-mode pulse path: pulseN goes through a 2-flop synchronizer, then an edge-detect flop. A tick occurs 3 clocks after the pulse rises. Pulses must be high/low for ≥2 clocks each.
- ior and iow together: the write takes effect and rdata is still driven. A read side-effect applies only if the address is STATUS.
- timer_irq is registered: it asserts the edge after done&irqen becomes 1 and drops the edge after it clears.
- Reset mid-count aborts all channels to reset values.

Optional Feature:
- Macro: IO_TIMER_PRESCALE_EN.
- When defined:
  - MODE[15:8] is a prescale value P.
  - Timer-mode ticks occur once every P+1 clocks, via an 8-bit per-channel prescale counter.
  - The prescale counter is cleared on INIT or MODE write and on reset.
  - Counter mode is unaffected.
- When undefined: MODE[15:8] is ignored, there is no prescale logic, and timer ticks occur every clock.

Test Plan:
- Reset, then read +0/+4 → rdata 0x0000; timer_irq 0.
- MODE0=0x0004, INIT0=5 → CNT0 reads 4,3,2,1,0 on successive cycles; STATUS0=0x0001 and running=0 after the 5th edge; timer_irq=1 one cycle later; STATUS read returns 0x0001, then the next read returns 0x0000 and irq drops.
- MODE1=0x0003 (counter, repeat), INIT1=3, 7 pulses on pulse1 (4 clk high/4 clk low) → done1 set after the 3rd and 6th pulse; CNT1=2 at end; STATUS1=0x8002; tick lags each pulse rise by 3 clocks.
- Timer repeat, INIT0=2, STATUS read exactly on the done edge → read returns old status and done remains 1 (set wins).
- INIT0=0x0010 then INIT0=0x0003 mid-count → CNT0=3 the next cycle, done after 3 more edges; INIT0=0 → running=0 and CNT0 stays 0.
- With IO_TIMER_PRESCALE_EN: MODE0=0x0200, INIT0=2 → done at edge 6 after the write; without the macro the same writes give done at edge 2.

Source files
------------

// File: rtl/io_timer_responder.sv
// Two-channel timer/counter IO responder (halfword MODE/STATUS/INIT/CNT registers).
// Optional build macro IO_TIMER_PRESCALE_EN adds an 8-bit timer-mode prescaler per channel.
module io_timer_responder #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [9:0]  BASE_ADDR = 10'h020
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ior,
    input  logic        iow,
    input  logic [9:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic        pulse0,
    input  logic        pulse1,
    output logic        timer_irq
);

    logic [9:0]  off;
    logic        hit;
    logic [1:0]  pulse_in;
    logic [15:0] chan_status [2];
    logic [15:0] chan_cnt    [2];
    logic [1:0]  chan_irq_req;

    // Offsets +0/+2/+4/+6 only: off[2] selects INIT/CNT, off[1] selects the channel.
    assign off      = addr - BASE_ADDR;
    assign hit      = (off[9:3] == 7'd0) && !off[0];
    assign pulse_in = {pulse1, pulse0};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_chan
            localparam logic CH = 1'(g);

            logic [2:0]       mode_r;
            logic [CNT_W-1:0] init_r;
            logic [CNT_W-1:0] cnt_r;
            logic             running;
            logic             done_t;
            logic             done_c;
            logic             sync1;
            logic             sync2;
            logic             pulse_d;
            logic             wr_mode;
            logic             wr_init;
            logic             rd_status;
            logic             timer_tick;
            logic             tick;
            logic             last;

            assign wr_mode   = iow && hit && !off[2] && (off[1] == CH);
            assign wr_init   = iow && hit &&  off[2] && (off[1] == CH);
            assign rd_status = ior && hit && !off[2] && (off[1] == CH);

`ifdef IO_TIMER_PRESCALE_EN
            logic [7:0] psc_val;
            logic [7:0] psc_cnt;

            assign timer_tick = (psc_cnt == psc_val);

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    psc_val <= '0;
                    psc_cnt <= '0;
                end else begin
                    if (wr_mode)
                        psc_val <= wdata[15:8];
                    if (wr_init || wr_mode)
                        psc_cnt <= '0;
                    else if (running && !mode_r[0])
                        psc_cnt <= timer_tick ? 8'd0 : psc_cnt + 8'd1;
                end
            end
`else
            assign timer_tick = 1'b1;
`endif

            // Counter mode ticks on the first synchronized high sample, three edges after the pulse rises.
            assign tick = running && (mode_r[0] ? (sync2 && !pulse_d) : timer_tick);
            assign last = tick && (cnt_r == CNT_W'(1));

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    mode_r  <= '0;
                    init_r  <= '0;
                    cnt_r   <= '0;
                    running <= 1'b0;
                    done_t  <= 1'b0;
                    done_c  <= 1'b0;
                    sync1   <= 1'b0;
                    sync2   <= 1'b0;
                    pulse_d <= 1'b0;
                end else begin
                    sync1   <= pulse_in[g];
                    sync2   <= sync1;
                    pulse_d <= sync2;
                    if (wr_init) begin
                        init_r  <= wdata[CNT_W-1:0];
                        cnt_r   <= wdata[CNT_W-1:0];
                        running <= |wdata[CNT_W-1:0];
                        done_t  <= 1'b0;
                        done_c  <= 1'b0;
                    end else begin
                        if (wr_mode)
                            mode_r <= wdata[2:0];
                        if (last) begin
                            if (mode_r[1]) begin
                                cnt_r <= init_r;
                            end else begin
                                cnt_r   <= '0;
                                running <= 1'b0;
                            end
                        end else if (tick) begin
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                        // A completion on the same edge as a clearing access wins.
                        if (last && !mode_r[0])
                            done_t <= 1'b1;
                        else if (wr_mode || rd_status)
                            done_t <= 1'b0;
                        if (last && mode_r[0])
                            done_c <= 1'b1;
                        else if (wr_mode || rd_status)
                            done_c <= 1'b0;
                    end
                end
            end

            assign chan_status[g]  = {running, 13'd0, done_c, done_t};
            assign chan_cnt[g]     = 16'(cnt_r);
            assign chan_irq_req[g] = (done_t || done_c) && mode_r[2];
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (ior && hit)
            rdata = off[2] ? chan_cnt[off[1]] : chan_status[off[1]];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            timer_irq <= 1'b0;
        else
            timer_irq <= |chan_irq_req;
    end

endmodule

// File: tb/tb_io_timer_responder.sv
// Directed self-checking bench for io_timer_responder: register map, timer/counter modes,
// read-clear with set priority, reload, prescale (when built with IO_TIMER_PRESCALE_EN) and reset.
module tb_io_timer_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ior = 1'b0;
    logic        iow = 1'b0;
    logic [9:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        pulse0 = 1'b0;
    logic        pulse1 = 1'b0;
    logic        timer_irq;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    localparam logic [9:0] A_MODE0 = 10'h020;
    localparam logic [9:0] A_MODE1 = 10'h022;
    localparam logic [9:0] A_INIT0 = 10'h024;
    localparam logic [9:0] A_INIT1 = 10'h026;

    io_timer_responder #(.CNT_W(16), .BASE_ADDR(10'h020)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ior       (ior),
        .iow       (iow),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .pulse0    (pulse0),
        .pulse1    (pulse1),
        .timer_irq (timer_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [15:0] d);
        addr = a;
        wdata = d;
        iow = 1'b1;
        @(posedge clock);
        #1;
        iow = 1'b0;
    endtask

    task automatic peek(input logic [9:0] a, output logic [15:0] v);
        addr = a;
        ior = 1'b1;
        #1;
        v = rdata;
        ior = 1'b0;
        #1;
    endtask

    task automatic read_edge(input logic [9:0] a, output logic [15:0] v);
        addr = a;
        ior = 1'b1;
        #1;
        v = rdata;
        @(posedge clock);
        #1;
        ior = 1'b0;
    endtask

    logic [15:0] v;
    int unsigned found;
    int unsigned exp_edge;

    initial begin
        step(2);
        reset_n = 1'b1;
        step(1);

        // Reset state
        peek(A_MODE0, v);  check("rst_status0", v, 16'h0000);
        peek(A_INIT0, v);  check("rst_cnt0", v, 16'h0000);
        check("rst_irq", 16'(timer_irq), 16'h0000);
        check("rdata_idle", rdata, 16'h0000);

        // Timer one-shot with irq
        do_write(A_MODE0, 16'h0004);
        do_write(A_INIT0, 16'h0005);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            peek(A_INIT0, v);
            check($sformatf("t1_cnt_%0d", k), v, 16'(5 - k));
        end
        peek(A_MODE0, v);  check("t1_status_done", v, 16'h0001);
        check("t1_irq_lag", 16'(timer_irq), 16'h0000);
        step(1);
        check("t1_irq_set", 16'(timer_irq), 16'h0001);
        read_edge(A_MODE0, v);  check("t1_read_status", v, 16'h0001);
        check("t1_irq_hold", 16'(timer_irq), 16'h0001);
        peek(A_MODE0, v);  check("t1_status_clr", v, 16'h0000);
        step(1);
        check("t1_irq_drop", 16'(timer_irq), 16'h0000);

        // Unmapped addresses
        peek(10'h021, v);  check("odd_addr", v, 16'h0000);
        peek(10'h028, v);  check("above_map", v, 16'h0000);
        peek(10'h01E, v);  check("below_map", v, 16'h0000);

        // Repeat mode, status read on the done edge: set wins
        do_write(A_MODE0, 16'h0006);
        do_write(A_INIT0, 16'h0002);
        step(1);
        read_edge(A_MODE0, v);  check("rep_read_old", v, 16'h8000);
        peek(A_MODE0, v);  check("rep_set_wins", v, 16'h8001);
        peek(A_INIT0, v);  check("rep_reload", v, 16'h0002);
        do_write(A_INIT0, 16'h0000);
        peek(A_MODE0, v);  check("rep_stop", v, 16'h0000);

        // Mid-count reload, then INIT=0
        do_write(A_MODE0, 16'h0000);
        do_write(A_INIT0, 16'h0010);
        step(2);
        peek(A_INIT0, v);  check("rl_cnt_pre", v, 16'h000E);
        do_write(A_INIT0, 16'h0003);
        peek(A_INIT0, v);  check("rl_cnt_new", v, 16'h0003);
        step(2);
        peek(A_MODE0, v);  check("rl_not_yet", v, 16'h8000);
        step(1);
        peek(A_MODE0, v);  check("rl_done", v, 16'h0001);
        do_write(A_INIT0, 16'h0000);
        peek(A_MODE0, v);  check("z_status", v, 16'h0000);
        step(3);
        peek(A_INIT0, v);  check("z_cnt", v, 16'h0000);

        // Counter mode, repeat, channel 1
        do_write(A_MODE1, 16'h0003);
        do_write(A_INIT1, 16'h0003);
        pulse1 = 1'b1;
        step(2);
        peek(A_INIT1, v);  check("ctr_lag2", v, 16'h0003);
        step(1);
        peek(A_INIT1, v);  check("ctr_lag3", v, 16'h0002);
        step(1);
        pulse1 = 1'b0;
        step(4);
        for (int p = 2; p <= 7; p++) begin
            pulse1 = 1'b1;
            step(4);
            pulse1 = 1'b0;
            step(4);
            if (p == 3) begin
                peek(A_INIT1, v);  check("ctr_p3_cnt", v, 16'h0003);
                peek(A_MODE1, v);  check("ctr_p3_done", v, 16'h8002);
                read_edge(A_MODE1, v);
                peek(A_MODE1, v);  check("ctr_p3_clr", v, 16'h8000);
            end
            if (p == 5) begin
                peek(A_MODE1, v);  check("ctr_p5_status", v, 16'h8000);
                peek(A_INIT1, v);  check("ctr_p5_cnt", v, 16'h0001);
            end
            if (p == 6) begin
                peek(A_MODE1, v);  check("ctr_p6_done", v, 16'h8002);
            end
        end
        peek(A_INIT1, v);  check("ctr_end_cnt", v, 16'h0002);
        peek(A_MODE1, v);  check("ctr_end_status", v, 16'h8002);
        check("ctr_no_irq", 16'(timer_irq), 16'h0000);
        do_write(A_INIT1, 16'h0000);

        // Prescale (or plain timer when the feature is not built)
`ifdef IO_TIMER_PRESCALE_EN
        exp_edge = 6;
`else
        exp_edge = 2;
`endif
        do_write(A_MODE0, 16'h0200);
        do_write(A_INIT0, 16'h0002);
        found = 0;
        for (int e = 1; e <= 20; e++) begin
            step(1);
            peek(A_MODE0, v);
            if (v[0] && found == 0) found = e;
        end
        check("psc_done_edge", 16'(found), 16'(exp_edge));

        // Reset mid-count
        do_write(A_MODE0, 16'h0004);
        do_write(A_INIT0, 16'h0010);
        step(3);
        reset_n = 1'b0;
        #1;
        peek(A_INIT0, v);  check("arst_cnt", v, 16'h0000);
        peek(A_MODE0, v);  check("arst_status", v, 16'h0000);
        check("arst_irq", 16'(timer_irq), 16'h0000);
        step(1);
        reset_n = 1'b1;
        step(2);
        peek(A_INIT0, v);  check("arst_idle_cnt", v, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
